jtdsp16_xbus_arb: RTL and testbench

External-bus arbiter and access sequencer for the DSP16 core. It shares the single external memory port (address/data to SDRAM or BRAM behind `ab`/`rb_din`) between three requesters: host program download, X-bus data reads (`up_xext` path), and instruction fetch when `ext_mode` is high. It runs at full `clk` rate, serialises accesses through a req/ack handshake with variable memory latency, and asserts `stall` so the core can freeze `cen2` until its access completes.

---
 rtl/jtdsp16_pkg.sv | 7 +
 rtl/jtdsp16_xbus_tmo.sv | 19 +
 rtl/jtdsp16_xbus_arb.sv | 104 ++++++++++
 tb/tb_jtdsp16_xbus_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtdsp16_pkg.sv
// jtdsp16_pkg: state and owner encodings shared by the external-bus arbiter
package jtdsp16_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
    localparam logic [1:0] OWN_PROG  = 2'd0;
    localparam logic [1:0] OWN_DATA  = 2'd1;
    localparam logic [1:0] OWN_FETCH = 2'd2;
endpackage

// File: rtl/jtdsp16_xbus_tmo.sv
// jtdsp16_xbus_tmo: access timeout counter, expired during the TMO-th enabled cycle
module jtdsp16_xbus_tmo #(
    parameter int TMO = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [7:0] cnt;

    assign expired = en && cnt == 8'(TMO - 1);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 8'd1;
    end
endmodule

// File: rtl/jtdsp16_xbus_arb.sv
// jtdsp16_xbus_arb: shares the external memory port between program download, X-bus reads and fetch
module jtdsp16_xbus_arb
    import jtdsp16_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int TMO    = 255,
    parameter int STARVE = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_req,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    output logic          prog_ok,
    input  logic          data_req,
    input  logic [AW-1:0] data_addr,
    output logic [DW-1:0] data_dout,
    output logic          data_ok,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic [DW-1:0] fetch_dout,
    output logic          fetch_ok,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic          fault
);
    state_t        st;
    logic [1:0]    owner;
    logic [7:0]    starve;
    logic          expired, pick_prog, pick_fetch, pick_data, done;
    logic [DW-1:0] rd;

    // a starved fetch jumps ahead of data, never ahead of a host write
    always_comb begin
        pick_prog  = prog_req;
        pick_fetch = !prog_req && fetch_req && (!data_req || starve == 8'(STARVE));
        pick_data  = !prog_req && data_req && !pick_fetch;
        done       = st == ACCESS && (mem_ack || expired);
        rd         = mem_ack ? mem_rdata : {DW{1'b1}};
    end

    assign stall = (data_req | fetch_req) & ~(data_ok | fetch_ok);

    jtdsp16_xbus_tmo #(.TMO(TMO)) u_tmo (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (st != ACCESS),
        .en     (st == ACCESS),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st         <= IDLE;
            owner      <= OWN_PROG;
            starve     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            prog_ok    <= 1'b0;
            data_ok    <= 1'b0;
            fetch_ok   <= 1'b0;
            data_dout  <= '0;
            fetch_dout <= '0;
            fault      <= 1'b0;
        end else begin
            prog_ok  <= 1'b0;
            data_ok  <= 1'b0;
            fetch_ok <= 1'b0;
            case (st)
                IDLE: if (prog_req || data_req || fetch_req) begin
                    st        <= ACCESS;
                    mem_req   <= 1'b1;
                    mem_we    <= pick_prog;
                    owner     <= pick_prog ? OWN_PROG : pick_fetch ? OWN_FETCH : OWN_DATA;
                    mem_addr  <= pick_prog ? prog_addr : pick_fetch ? fetch_addr : data_addr;
                    mem_wdata <= prog_data;
                    if (pick_fetch) starve <= '0;
                    else if (pick_data) starve <= !fetch_req ? 8'd0 : starve == 8'(STARVE) ? starve : starve + 8'd1;
                end
                ACCESS: if (done) begin
                    st       <= DONE;
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    fault    <= fault || !mem_ack;
                    prog_ok  <= owner == OWN_PROG;
                    data_ok  <= owner == OWN_DATA;
                    fetch_ok <= owner == OWN_FETCH;
                    if (owner == OWN_DATA) data_dout <= rd;
                    if (owner == OWN_FETCH) fetch_dout <= rd;
                end
                DONE: st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtdsp16_xbus_arb.sv
// tb_jtdsp16_xbus_arb: randomized requesters and memory against a scoreboard of grants and completions
module tb_jtdsp16_xbus_arb;
    localparam int AW = 16, DW = 16, TMO = 16, STARVE = 2, NOACK = 1000;
    localparam logic [1:0] O_PROG = 2'd0, O_DATA = 2'd1, O_FETCH = 2'd2;

    logic clk = 1'b0, rst_n = 1'b0, rst_q = 1'b0;
    logic prog_req = 0, data_req = 0, fetch_req = 0, mem_ack = 0;
    logic [AW-1:0] prog_addr = '0, data_addr = '0, fetch_addr = '0;
    logic [DW-1:0] prog_data = '0, mem_rdata = '0;
    logic prog_ok, data_ok, fetch_ok, mem_req, mem_we, stall, fault;
    logic [DW-1:0] data_dout, fetch_dout, mem_wdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;
    always @(posedge clk) rst_q <= rst_n;

    jtdsp16_xbus_arb #(.AW(AW), .DW(DW), .TMO(TMO), .STARVE(STARVE)) dut (
        .clk(clk), .rst_n(rst_n),
        .prog_req(prog_req), .prog_addr(prog_addr), .prog_data(prog_data), .prog_ok(prog_ok),
        .data_req(data_req), .data_addr(data_addr), .data_dout(data_dout), .data_ok(data_ok),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_dout(fetch_dout), .fetch_ok(fetch_ok),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .fault(fault)
    );

    typedef struct { logic [1:0] own; logic [AW-1:0] addr; logic [DW-1:0] wdata; } grant_t;
    typedef struct { logic [1:0] own; logic [DW-1:0] data; int due; logic flt; } done_t;
    grant_t gq[$];
    done_t  dq[$];
    logic [1:0] seq[$];
    logic [1:0] exp_seq [6] = '{O_DATA, O_DATA, O_FETCH, O_DATA, O_DATA, O_FETCH};

    int vectors = 0, miscompares = 0, cyc = 0;
    int starve = 0, acc = 0, lat = 0, fix_lat = -1, pct = 40;
    bit busy = 0, en_rand = 0, spur = 0, use_fix = 0, rec_on = 0;
    bit [2:0] mask = 3'b111;
    logic [1:0] cur_own = O_PROG;
    logic [DW-1:0] fix_rdata = '0;
    logic mfault = 0, prev_mreq = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // one clock of stimulus: requesters, reference arbitration and the memory responder
    task automatic step();
        grant_t g;
        done_t d;
        @(posedge clk);
        #1;
        cyc++;
        mem_ack = 1'b0;
        if (mem_req && !prev_mreq && (prog_req || data_req || fetch_req)) begin
            cur_own = prog_req ? O_PROG : (fetch_req && (starve == STARVE || !data_req)) ? O_FETCH : O_DATA;
            if (cur_own == O_FETCH) starve = 0;
            else if (cur_own == O_DATA) starve = fetch_req ? (starve < STARVE ? starve + 1 : starve) : 0;
            g.own = cur_own;
            g.addr = cur_own == O_PROG ? prog_addr : cur_own == O_DATA ? data_addr : fetch_addr;
            g.wdata = prog_data;
            gq.push_back(g);
            busy = 1;
            acc = 0;
            lat = fix_lat >= 0 ? fix_lat : int'($urandom_range(0, 5));
        end
        prev_mreq = mem_req;
        if (busy) begin
            acc++;
            if (acc == lat + 1 || acc == TMO) begin
                d.own = cur_own;
                d.due = cyc + 1;
                if (acc == lat + 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = use_fix ? fix_rdata : 16'($urandom);
                    d.data = mem_rdata;
                end else begin
                    mfault = 1'b1;
                    d.data = '1;
                end
                d.flt = mfault;
                dq.push_back(d);
                busy = 0;
            end
        end else if (spur) begin
            mem_ack = 1'b1;
            mem_rdata = 16'hdead;
        end
        if (prog_ok) prog_req = 1'b0;
        if (data_ok) data_req = 1'b0;
        if (fetch_ok) fetch_req = 1'b0;
        if (en_rand) begin
            if (mask[0] && !prog_req && $urandom_range(0, 99) < pct / 3) begin
                prog_req = 1'b1; prog_addr = {2'b00, 14'($urandom)}; prog_data = 16'($urandom);
            end
            if (mask[1] && !data_req && $urandom_range(0, 99) < pct) begin
                data_req = 1'b1; data_addr = {2'b01, 14'($urandom)};
            end
            if (mask[2] && !fetch_req && $urandom_range(0, 99) < pct) begin
                fetch_req = 1'b1; fetch_addr = {2'b10, 14'($urandom)};
            end
        end
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        do begin
            step();
            n++;
        end while ((prog_req || data_req || fetch_req || busy || dq.size() != 0) && n < max);
        if (prog_req || data_req || fetch_req || busy || dq.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_wait: still busy after %0d cycles, required idle", max);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        {prog_req, data_req, fetch_req, mem_ack} = '0;
        busy = 0; starve = 0; mfault = 0; prev_mreq = 0;
        gq.delete();
        dq.delete();
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    // monitor: pops the scoreboard whenever the DUT starts an access or completes one
    logic [DW-1:0] m_dd = '0, m_fd = '0;
    logic m_flt = 0, prev_mr = 0, exp_ok;
    logic [2:0] okv;
    grant_t mg;
    done_t md;
    always @(negedge clk) begin
        if (!rst_q) begin
            check("rst_mem_req", {31'd0, mem_req}, 0);
            check("rst_ok", {prog_ok, data_ok, fetch_ok}, 0);
            check("rst_fault", {31'd0, fault}, 0);
            check("rst_addr", {16'd0, mem_addr}, 0);
            check("rst_dout", {data_dout, fetch_dout}, 0);
            m_dd = '0; m_fd = '0; m_flt = 1'b0;
        end else begin
            if (mem_req && !prev_mr) begin
                if (rec_on) seq.push_back(mem_addr[AW-1 -: 2]);
                if (gq.size() == 0) check("unexpected_grant", {31'd0, mem_req}, 0);
                else begin
                    mg = gq.pop_front();
                    check("grant_addr", {16'd0, mem_addr}, {16'd0, mg.addr});
                    check("grant_we", {31'd0, mem_we}, {31'd0, mg.own == O_PROG});
                    if (mg.own == O_PROG) check("grant_wdata", {16'd0, mem_wdata}, {16'd0, mg.wdata});
                end
            end
            while (dq.size() > 0 && dq[0].due < cyc) begin
                md = dq.pop_front();
                check("ok_missing_at_due", cyc, md.due);
            end
            exp_ok = dq.size() > 0 && dq[0].due == cyc;
            okv = exp_ok ? 3'b100 >> dq[0].own : 3'b000;
            check("ok_pulse", {prog_ok, data_ok, fetch_ok}, {29'd0, okv});
            if (exp_ok) begin
                md = dq.pop_front();
                if (md.own == O_DATA) m_dd = md.data;
                if (md.own == O_FETCH) m_fd = md.data;
                m_flt = md.flt;
            end
            check("data_dout", {16'd0, data_dout}, {16'd0, m_dd});
            check("fetch_dout", {16'd0, fetch_dout}, {16'd0, m_fd});
            check("fault", {31'd0, fault}, {31'd0, m_flt});
            check("stall", {31'd0, stall}, {31'd0, (data_req | fetch_req) & ~(okv[1] | okv[0])});
        end
        prev_mr = mem_req;
    end

    initial begin
        do_reset(3);
        en_rand = 1; mask = 3'b111; pct = 40; fix_lat = -1; use_fix = 0;
        repeat (600) step();
        en_rand = 0;
        run_until_idle(200);

        fetch_addr = 16'h0123; fetch_req = 1; fix_lat = 3; fix_rdata = 16'hbeef; use_fix = 1;
        run_until_idle(50);
        use_fix = 0;

        prog_addr = 16'h1111; prog_data = 16'h5a5a; data_addr = 16'h4222; fetch_addr = 16'h8333;
        {prog_req, data_req, fetch_req} = 3'b111; fix_lat = 0;
        run_until_idle(50);

        seq.delete();
        rec_on = 1; en_rand = 1; mask = 3'b110; pct = 100;
        repeat (30) step();
        en_rand = 0; rec_on = 0;
        run_until_idle(50);
        check("starve_seq_len", {31'd0, seq.size() >= 6}, 1);
        for (int i = 0; i < 6 && i < seq.size(); i++) check("starve_seq", {30'd0, seq[i]}, {30'd0, exp_seq[i]});

        data_addr = 16'h4444; data_req = 1; fix_lat = TMO - 1;
        run_until_idle(50);
        data_addr = 16'h4555; data_req = 1; fix_lat = NOACK;
        run_until_idle(50);

        data_addr = 16'h4666; data_req = 1; fix_lat = 0;
        for (int n = 0; n < 50 && !data_ok; n++) step();
        check("spur_setup_ok", {31'd0, data_ok}, 1);
        spur = 1;
        repeat (2) step();
        spur = 0;
        repeat (5) step();

        data_addr = 16'h4777; data_req = 1; fix_lat = NOACK;
        repeat (5) step();
        do_reset(2);
        repeat (2) step();
        fetch_addr = 16'h8888; fetch_req = 1; fix_lat = 1;
        run_until_idle(50);

        repeat (3) step();
        check("queues_drained", gq.size() + dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
